// File: rtl/echo_mc_if.sv
// echo_mc_if: control, audio and strobe bundle for the echo_mc effect.
// master drives controls/audio_in; slave (echo_mc) drives audio_out and strobes.
interface echo_mc_if #(
  parameter int NBITS    = 16,
  parameter int CHANNELS = 2
);
  logic                      enable_in;
  logic                      mode_in;
  logic [15:0]               delay_in;
  logic [15:0]               decay_in;
  logic [CHANNELS*NBITS-1:0] audio_in;
  logic [CHANNELS*NBITS-1:0] audio_out;
  logic                      tick_out;
  logic                      out_valid;

  modport master (
    output enable_in, mode_in, delay_in, decay_in, audio_in,
    input  audio_out, tick_out, out_valid
  );

  modport slave (
    input  enable_in, mode_in, delay_in, decay_in, audio_in,
    output audio_out, tick_out, out_valid
  );
endinterface

// File: rtl/echo_mc.sv
// echo_mc: multichannel echo, one shared datapath time-sliced per sample tick.
// Ports: clk, arst_n (async active-low), io (echo_mc_if.slave bundle).
module echo_mc #(
  parameter int NBITS     = 16,
  parameter int CHANNELS  = 2,
  parameter int MAX_DELAY = 1024,
  parameter int TICK_DIV  = 1024
) (
  input logic      clk,
  input logic      arst_n,
  echo_mc_if.slave io
);
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int FW = $clog2(MAX_DELAY + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [15:0] G_MAX = 16'h8000;

  if (TICK_DIV < 3*CHANNELS+2) begin : g_chk
    $error("echo_mc: TICK_DIV too small for CHANNELS");
  end

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  state_t state, state_nx;

  logic [TW-1:0] cnt;
  logic          tick;
  logic [CW-1:0] ch;
  logic          last;
  logic [AW-1:0] wptr, raddr;
  logic [FW-1:0] fill;
  logic [31:0]   rsum;
  logic          en_q, mode_q;
  logic [15:0]   dly_q, g_q, dly_eff, g_eff;

  logic signed [NBITS-1:0] x_q   [CHANNELS];
  logic signed [NBITS-1:0] y_buf [CHANNELS];
  logic signed [NBITS-1:0] mem   [CHANNELS][MAX_DELAY];

  logic signed [NBITS-1:0]  d_q, y_q, x_cur, y_sat, rd;
  logic signed [NBITS+16:0] prod;
  logic signed [NBITS+1:0]  sum;
  logic [CHANNELS*NBITS-1:0] out_q;
  logic unused_bits;

  assign tick = (cnt == TW'(TICK_DIV-1));
  assign last = (ch == CW'(CHANNELS-1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt <= '0;
    else         cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_comb begin
    dly_eff = io.delay_in;
    if (io.delay_in == 16'd0)
      dly_eff = 16'd1;
    else if (32'(io.delay_in) > 32'(MAX_DELAY))
      dly_eff = 16'(MAX_DELAY);
    g_eff = (io.decay_in > G_MAX) ? G_MAX : io.decay_in;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = READ;
      READ:    state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = last ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // (wptr - D) mod MAX_DELAY, with D in 1..MAX_DELAY
  always_comb begin
    rsum  = 32'(wptr) + 32'(MAX_DELAY) - 32'(dly_q);
    raddr = (rsum >= 32'(MAX_DELAY)) ?
            AW'(rsum - 32'(MAX_DELAY)) : AW'(rsum);
    // history not yet written reads as silence
    rd    = (32'(dly_q) > 32'(fill)) ? '0 : mem[ch][raddr];
  end

  always_comb begin
    x_cur = x_q[ch];
    prod  = $signed(d_q) * $signed({1'b0, g_q});
    sum   = {{2{x_cur[NBITS-1]}}, x_cur} + prod[NBITS+16:15];
    y_sat = sum[NBITS-1:0];
    if (sum[NBITS+1:NBITS-1] != '0 && sum[NBITS+1:NBITS-1] != '1)
      y_sat = sum[NBITS+1] ? {1'b1, {(NBITS-1){1'b0}}}
                           : {1'b0, {(NBITS-1){1'b1}}};
  end

  assign unused_bits = ^prod[14:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ch     <= '0;
      wptr   <= '0;
      fill   <= '0;
      en_q   <= 1'b0;
      mode_q <= 1'b0;
      dly_q  <= 16'd1;
      g_q    <= '0;
      d_q    <= '0;
      y_q    <= '0;
      out_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        x_q[k]   <= '0;
        y_buf[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (tick) begin
          en_q   <= io.enable_in;
          mode_q <= io.mode_in;
          dly_q  <= dly_eff;
          g_q    <= g_eff;
          for (int k = 0; k < CHANNELS; k++)
            x_q[k] <= io.audio_in[k*NBITS +: NBITS];
        end
        READ: d_q <= rd;
        CALC: y_q <= en_q ? y_sat : x_cur;
        WRITE: begin
          y_buf[ch] <= y_q;
          ch        <= last ? '0 : ch + 1'b1;
          if (last)
            for (int k = 0; k < CHANNELS; k++)
              out_q[k*NBITS +: NBITS] <=
                (CW'(k) == ch) ? y_q : y_buf[k];
        end
        DONE: begin
          wptr <= (wptr == AW'(MAX_DELAY-1)) ? '0 : wptr + 1'b1;
          if (fill != FW'(MAX_DELAY)) fill <= fill + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // delay memory holds no reset; fill gates stale contents
  always_ff @(posedge clk) begin
    if (state == WRITE)
      mem[ch][wptr] <= (mode_q && en_q) ? y_q : x_cur;
  end

  assign io.audio_out = out_q;
  assign io.tick_out  = tick;
  assign io.out_valid = (state == DONE);
endmodule

// File: tb/tb_echo_mc.sv
// tb_echo_mc: scoreboard bench for echo_mc (NBITS=16, CHANNELS=2,
// MAX_DELAY=8, TICK_DIV=16).
module tb_echo_mc;
  localparam int NB = 16;
  localparam int CH = 2;
  localparam int MD = 8;
  localparam int TD = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  echo_mc_if #(.NBITS(NB), .CHANNELS(CH)) bus ();

  echo_mc #(
    .NBITS(NB), .CHANNELS(CH), .MAX_DELAY(MD), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .arst_n(arst_n), .io(bus)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  int  lat;
  time vt;
  bit  tmo;

  task automatic do_reset;
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    #2 arst_n = 1'b1;
  endtask

  task automatic set_cfg(input bit en, input bit md,
                         input logic [15:0] dl, input logic [15:0] dc);
    bus.enable_in = en;
    bus.mode_in   = md;
    bus.delay_in  = dl;
    bus.decay_in  = dc;
  endtask

  // drive one sample pair, wait for its tick and its out_valid
  task automatic run_frame(input int a0, input int a1);
    int n;
    bus.audio_in = {16'(a1), 16'(a0)};
    tmo = 1'b0;
    got = 'x;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.tick_out && n < 40);
    if (!bus.tick_out) begin tmo = 1'b1; return; end
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!bus.out_valid && lat < 20);
    if (!bus.out_valid) tmo = 1'b1;
    got = bus.audio_out;
    vt  = $time;
  endtask

  task automatic test_reset;
    #1 arst_n = 1'b0;
    #1;
    total++;
    if (bus.audio_out !== '0)
      $display("FAIL rst_audio got %h want 0", bus.audio_out);
    else passed++;
    total++;
    if (bus.tick_out !== 1'b0)
      $display("FAIL rst_tick got %b want 0", bus.tick_out);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", bus.out_valid);
    else passed++;
    @(negedge clk);
    #2 arst_n = 1'b1;
  endtask

  task automatic test_ff_echo;
    int e0[7] = '{1000, 0, 0, 500, 0, 0, 0};
    logic [31:0] e;
    do_reset;
    set_cfg(1'b1, 1'b0, 16'd3, 16'h4000);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({16'(0), 16'(e0[i])});
      run_frame(i == 0 ? 1000 : 0, 0);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL ff_echo[%0d] got %h want %h", i, got, e);
      else passed++;
    end
  endtask

  task automatic test_fb_echo;
    int e0[10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};
    logic [31:0] e;
    do_reset;
    set_cfg(1'b1, 1'b1, 16'd3, 16'h4000);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({16'(0), 16'(e0[i])});
      run_frame(i == 0 ? 1000 : 0, 0);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL fb_echo[%0d] got %h want %h", i, got, e);
      else passed++;
    end
  endtask

  task automatic test_saturate;
    int e0[3] = '{30000, 32767, 32767};
    int e1[3] = '{-30000, -32768, -32768};
    logic [31:0] e;
    do_reset;
    set_cfg(1'b1, 1'b0, 16'd1, 16'h8000);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'(e1[i]), 16'(e0[i])});
      run_frame(30000, -30000);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL saturate[%0d] got %h want %h", i, got, e);
      else passed++;
    end
  endtask

  task automatic test_clamp;
    int i0a[3] = '{1000, 0, 0};
    int i1a[3] = '{-3, 0, 0};
    int e0a[3] = '{1000, 500, 0};
    int e1a[3] = '{-3, -2, 0};
    int e0b[10] = '{1000, 0, 0, 0, 0, 0, 0, 0, 500, 0};
    int e1b[10] = '{0, -1000, 0, 0, 0, 0, 0, 0, 0, -500};
    logic [31:0] e;
    do_reset;
    set_cfg(1'b1, 1'b0, 16'd0, 16'h4000);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'(e1a[i]), 16'(e0a[i])});
      run_frame(i0a[i], i1a[i]);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL delay_zero[%0d] got %h want %h", i, got, e);
      else passed++;
    end
    do_reset;
    set_cfg(1'b1, 1'b0, 16'd100, 16'h4000);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({16'(e1b[i]), 16'(e0b[i])});
      run_frame(i == 0 ? 1000 : 0, i == 1 ? -1000 : 0);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL delay_big[%0d] got %h want %h", i, got, e);
      else passed++;
    end
    do_reset;
    set_cfg(1'b1, 1'b0, 16'd1, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({16'(0), 16'(1000)});
      run_frame(i == 0 ? 1000 : 0, 0);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL decay_clamp[%0d] got %h want %h", i, got, e);
      else passed++;
    end
  endtask

  task automatic test_bypass;
    int i0[4] = '{1234, -5678, 32767, 0};
    int i1[4] = '{-5678, 1234, -32768, 1};
    logic [31:0] e;
    time prev;
    prev = 0;
    do_reset;
    set_cfg(1'b0, 1'b1, 16'd3, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({16'(i1[i]), 16'(i0[i])});
      run_frame(i0[i], i1[i]);
      e = exp_q.pop_front();
      total++;
      if (tmo || got !== e)
        $display("FAIL bypass[%0d] got %h want %h", i, got, e);
      else passed++;
      if (i > 0) begin
        total++;
        if (tmo || vt - prev != 160)
          $display("FAIL bypass_period[%0d] got %0t want 160",
                   i, vt - prev);
        else passed++;
      end
      prev = vt;
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    logic [31:0] e;
    do_reset;
    set_cfg(1'b0, 1'b0, 16'd1, 16'h0000);
    exp_q.push_back({16'(-1000), 16'(1000)});
    run_frame(1000, -1000);
    e = exp_q.pop_front();
    total++;
    if (tmo || got !== e)
      $display("FAIL pre_abort got %h want %h", got, e);
    else passed++;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.tick_out && n < 40);
    total++;
    if (bus.tick_out !== 1'b1)
      $display("FAIL abort_tick got %b want 1", bus.tick_out);
    else passed++;
    @(posedge clk);
    @(posedge clk);
    #1 arst_n = 1'b0;
    #1;
    total++;
    if (bus.audio_out !== '0)
      $display("FAIL abort_audio got %h want 0", bus.audio_out);
    else passed++;
    total++;
    if (bus.tick_out !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL abort_strobes got %b%b want 00",
               bus.tick_out, bus.out_valid);
    else passed++;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    total++;
    if (n != 0)
      $display("FAIL abort_no_valid got %0d want 0", n);
    else passed++;
    @(negedge clk);
    #2 arst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.tick_out && n < 40);
    total++;
    if (!bus.tick_out || n + 1 != 16)
      $display("FAIL first_tick_edge got %0d want 16", n + 1);
    else passed++;
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!bus.out_valid && lat < 20);
    total++;
    if (!bus.out_valid || lat != 7)
      $display("FAIL valid_latency got %0d want 7", lat);
    else passed++;
  endtask

  initial begin
    set_cfg(1'b0, 1'b0, 16'd1, 16'h0000);
    bus.audio_in = '0;
    test_reset;
    test_ff_echo;
    test_fb_echo;
    test_saturate;
    test_clamp;
    test_bypass;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/echo_mc.md
ECHO_MC -- requirements
Module: echo_mc

Interface
REQ-001 Parameter NBITS, 16: sample width per channel, signed two's complement.
REQ-002 Parameter CHANNELS, 2: independent audio channels sharing one datapath.
REQ-003 Parameter MAX_DELAY, 1024: delay-line depth per channel, in samples.
REQ-004 Parameter TICK_DIV, 1024: clock cycles per sample period; elaboration SHALL fail if TICK_DIV < 3*CHANNELS+2.
REQ-005 clk  in  1  single system clock; all state on its rising edge.
REQ-006 arst_n  in  1  reset, asynchronous and active-low.
REQ-007 enable_in  in  1  1 = echo applied, 0 = dry pass-through.
REQ-008 mode_in  in  1  0 = feed-forward echo, 1 = feedback (recirculating) echo.
REQ-009 delay_in  in  16  echo delay in samples.
REQ-010 decay_in  in  16  echo gain, unsigned Q1.15 (0x8000 = 1.0).
REQ-011 audio_in  in  CHANNELS*NBITS  input samples; channel k at bits [k*NBITS +: NBITS].
REQ-012 audio_out  out  CHANNELS*NBITS  processed samples, same packing.
REQ-013 tick_out  out  1  one-cycle sample-rate strobe.
REQ-014 out_valid  out  1  one-cycle pulse when audio_out updates.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick_out high exactly when count = TICK_DIV-1.
REQ-016 On the tick_out cycle, audio_in, enable_in, mode_in, effective delay and effective decay SHALL be captured; changes at other times have no effect on the current sample.
REQ-017 Effective delay D = 1 if delay_in = 0; MAX_DELAY if delay_in > MAX_DELAY; else delay_in.
REQ-018 Effective decay G = min(decay_in, 0x8000).
REQ-019 FSM states IDLE, READ, CALC, WRITE, DONE: IDLE->READ after tick; READ->CALC->WRITE per channel; WRITE->READ (next channel) or DONE (last channel); DONE->IDLE.
REQ-020 READ SHALL address channel memory at (wptr - D) mod MAX_DELAY; data used in CALC.
REQ-021 Delayed sample d SHALL read as 0 when D > fill, where fill counts written samples, saturating at MAX_DELAY.
REQ-022 CALC: p = (d * G) arithmetic-shifted right 15 (floor); y = x + p in NBITS+1 bits, saturated to [-2^(NBITS-1), 2^(NBITS-1)-1].
REQ-023 enable=0: y = x, regardless of d.
REQ-024 WRITE: memory at wptr SHALL receive x when mode=0 or enable=0, y when mode=1 and enable=1.
REQ-025 DONE: all audio_out channels updated together, out_valid high one cycle, wptr advanced mod MAX_DELAY (wrap to 0), fill incremented with saturation.
REQ-026 out_valid SHALL assert exactly 3*CHANNELS+1 cycles after tick_out.
REQ-027 A tick arriving while not in IDLE is impossible by REQ-004; no overlap handling required.
REQ-028 Delay memory is not reset; correctness after reset relies solely on REQ-021.

Reset
REQ-029 arst_n low SHALL immediately force audio_out = 0, tick_out = 0, out_valid = 0, FSM = IDLE, tick counter = 0, wptr = 0, fill = 0, regardless of clock.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no out_valid; first tick_out SHALL occur TICK_DIV cycles after the first clock edge with arst_n high.

Verification (NBITS=16, CHANNELS=2, MAX_DELAY=8, TICK_DIV=16)
REQ-031 Assert arst_n low during CALC -> outputs 0 at once; after release tick_out on the 16th edge, out_valid 7 cycles later.
REQ-032 mode=0, enable=1, delay=3, decay=0x4000, ch0 impulse 1000 then zeros -> ch0 outputs 1000,0,0,500,0,0,0; ch1 all 0.
REQ-033 Same with mode=1 -> ch0 outputs 1000,0,0,500,0,0,250,0,0,125.
REQ-034 ch0 input 30000 constant, delay=1, decay=0x8000, mode=0 -> second output 32767; input -30000 -> -32768.
REQ-035 delay_in=0 -> behaves as D=1; delay_in=100 -> behaves as D=8, echo appears after wptr wraps; first 8 samples after reset see zero history.
REQ-036 enable=0, inputs 1234/-5678 -> audio_out equals audio_in each sample; out_valid still pulses every 16 cycles.
